// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I funct3 load/store encodings and the LSU state type
package rv32_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} lsu_state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory bus (addr/req/we/wmask/wdata out of the LSU, ready/rdata back), master = LSU side
interface load_store_unit_if;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master(output mem_addr, mem_req, mem_we, mem_wmask, mem_wdata, input mem_ready, mem_rdata);
  modport slave(input mem_addr, mem_req, mem_we, mem_wmask, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/lsu_data_align.sv
// lsu_data_align: combinational lane steering (funct3/addr/storeData/mem_rdata in; wmask/wdata/load_val/illegal out)
module lsu_data_align
  import rv32_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] storeData,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic        illegal
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        bad_f3;
  logic        misaligned;
  always_comb begin
    b = 8'(mem_rdata >> {addr, 3'b000});
    h = 16'(mem_rdata >> {addr, 3'b000});
    bad_f3 = is_store ? (funct3 > F3_SW) : (funct3[1:0] == 2'b11 || funct3 == 3'b110);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr != 2'b00);
    illegal = bad_f3 || misaligned;
    wmask = !is_store ? 4'b0000 :
            funct3 == F3_SB ? 4'b0001 << addr :
            funct3 == F3_SH ? 4'b0011 << addr :
            funct3 == F3_SW ? 4'b1111 : 4'b0000;
    wdata = funct3 == F3_SB ? {4{storeData[7:0]}} :
            funct3 == F3_SH ? {2{storeData[15:0]}} : storeData;
    load_val = funct3 == F3_LB  ? {{24{b[7]}}, b} :
               funct3 == F3_LH  ? {{16{h[15]}}, h} :
               funct3 == F3_LBU ? {24'b0, b} :
               funct3 == F3_LHU ? {16'b0, h} :
               funct3 == F3_LW  ? mem_rdata : 32'b0;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I LSU (start/isLoad/isStore/funct3/ALUOut/storeData in; mem bus; busy/done/fault/loadData out)
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      isLoad,
  input  logic                      isStore,
  input  logic [2:0]                funct3,
  input  logic [31:0]               ALUOut,
  input  logic [31:0]               storeData,
  load_store_unit_if.master         mem,
  output logic                      busy,
  output logic                      done,
  output logic                      fault,
  output logic [31:0]               loadData
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  lsu_state_t  state, state_d;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic        store_q;
  logic        fault_q;
  logic [15:0] cnt;
  logic        idle, accept, to_hit;
  logic [3:0]  wmask;
  logic [31:0] wdata, load_val;
  logic        illegal;
  assign idle   = state == S_IDLE;
  assign accept = idle && start && (isLoad ^ isStore);
  assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
  assign mem.mem_req = state == S_ACCESS;
  assign busy  = !idle;
  assign done  = state == S_DONE;
  assign fault = done && fault_q;
  lsu_data_align u_align (
    .is_store (idle ? isStore : store_q),
    .funct3   (idle ? funct3 : f3_q),
    .addr     (idle ? ALUOut[1:0] : alo_q),
    .storeData(storeData),
    .mem_rdata(mem.mem_rdata),
    .wmask    (wmask),
    .wdata    (wdata),
    .load_val (load_val),
    .illegal  (illegal)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   state_d = accept ? (illegal ? S_DONE : S_ACCESS) : S_IDLE;
      S_ACCESS: state_d = (mem.mem_ready || to_hit) ? S_DONE : S_ACCESS;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q          <= '0;
      alo_q         <= '0;
      store_q       <= 1'b0;
      fault_q       <= 1'b0;
      cnt           <= '0;
      loadData      <= '0;
      mem.mem_addr  <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_wmask <= '0;
      mem.mem_wdata <= '0;
    end else begin
      if (accept) begin
        f3_q          <= funct3;
        alo_q         <= ALUOut[1:0];
        store_q       <= isStore;
        fault_q       <= illegal;
        cnt           <= '0;
        mem.mem_addr  <= {ALUOut[31:2], 2'b00};
        mem.mem_we    <= isStore;
        mem.mem_wmask <= illegal ? 4'b0000 : wmask;
        mem.mem_wdata <= wdata;
      end
      if (state == S_ACCESS) begin
        cnt     <= cnt + 16'd1;
        fault_q <= !mem.mem_ready;
        if (mem.mem_ready && !store_q) loadData <= load_val;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus wait/timeout/reset/ignored-start sequences for load_store_unit
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        isLoad = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ALUOut = '0;
  logic [31:0] storeData = '0;
  logic        busy, done, fault;
  logic [31:0] loadData;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] exp_ld = '0;
  load_store_unit_if m ();
  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .isLoad(isLoad), .isStore(isStore),
    .funct3(funct3), .ALUOut(ALUOut), .storeData(storeData), .mem(m.master),
    .busy(busy), .done(done), .fault(fault), .loadData(loadData)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    logic        flt;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [31:0] lv;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    start = 1'b1;
    isLoad = ld;
    isStore = st;
    funct3 = f3;
    ALUOut = a;
    storeData = sd;
  endtask
  initial begin
    int n;
    v[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
    v[1]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1'b0, 4'h8, 32'hA5A5A5A5, 32'h0};
    v[2]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        1'b0, 4'hC, 32'h12341234, 32'h0};
    v[3]  = '{1'b1, 1'b0, 3'b000, 32'h201, 32'h0,        32'h0000F000, 1'b0, 4'h0, 32'h0,        32'hFFFFFFF0};
    v[4]  = '{1'b1, 1'b0, 3'b100, 32'h201, 32'h0,        32'h0000F000, 1'b0, 4'h0, 32'h0,        32'h000000F0};
    v[5]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h80010000, 1'b0, 4'h0, 32'h0,        32'hFFFF8001};
    v[6]  = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0,        32'h80010000, 1'b0, 4'h0, 32'h0,        32'h00008001};
    v[7]  = '{1'b1, 1'b0, 3'b010, 32'h204, 32'h0,        32'h12345678, 1'b0, 4'h0, 32'h0,        32'h12345678};
    v[8]  = '{1'b1, 1'b0, 3'b010, 32'h302, 32'h0,        32'hFFFFFFFF, 1'b1, 4'h0, 32'h0,        32'h0};
    v[9]  = '{1'b0, 1'b1, 3'b001, 32'h301, 32'h00005555, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    v[10] = '{1'b1, 1'b0, 3'b011, 32'h400, 32'h0,        32'hFFFFFFFF, 1'b1, 4'h0, 32'h0,        32'h0};
    v[11] = '{1'b0, 1'b1, 3'b100, 32'h400, 32'h11111111, 32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
    v[12] = '{1'b1, 1'b0, 3'b000, 32'h003, 32'h0,        32'h7F000000, 1'b0, 4'h0, 32'h0,        32'h0000007F};
    v[13] = '{1'b0, 1'b1, 3'b000, 32'h000, 32'h12345677, 32'h0,        1'b0, 4'h1, 32'h77777777, 32'h0};
    v[14] = '{1'b1, 1'b0, 3'b001, 32'h200, 32'h0,        32'h00008000, 1'b0, 4'h0, 32'h0,        32'hFFFF8000};
    m.mem_ready = 1'b1;
    m.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(m.mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_wmask", 32'(m.mem_wmask), 32'd0);
    chk("rst_addr", m.mem_addr, 32'd0);
    chk("rst_wdata", m.mem_wdata, 32'd0);
    chk("rst_load", loadData, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      issue(v[i].ld, v[i].st, v[i].f3, v[i].addr, v[i].sd);
      m.mem_ready = 1'b1;
      m.mem_rdata = v[i].rd;
      @(negedge clk);
      start = 1'b0;
      if (v[i].flt) begin
        chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
        chk($sformatf("v%0d_fault", i), 32'(fault), 32'd1);
        chk($sformatf("v%0d_noreq", i), 32'(m.mem_req), 32'd0);
        chk($sformatf("v%0d_keep", i), loadData, exp_ld);
      end else begin
        chk($sformatf("v%0d_req", i), 32'(m.mem_req), 32'd1);
        chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
        chk($sformatf("v%0d_early", i), 32'(done), 32'd0);
        chk($sformatf("v%0d_addr", i), m.mem_addr, {v[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_we", i), 32'(m.mem_we), 32'(v[i].st));
        chk($sformatf("v%0d_wmask", i), 32'(m.mem_wmask), 32'(v[i].wm));
        if (v[i].st) chk($sformatf("v%0d_wdata", i), m.mem_wdata, v[i].wd);
        @(negedge clk);
        chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
        chk($sformatf("v%0d_fault", i), 32'(fault), 32'd0);
        if (v[i].ld) exp_ld = v[i].lv;
        chk($sformatf("v%0d_load", i), loadData, exp_ld);
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    end
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    m.mem_ready = 1'b0;
    m.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ws%0d_req", i), 32'(m.mem_req), 32'd1);
      chk($sformatf("ws%0d_addr", i), m.mem_addr, 32'h500);
      chk($sformatf("ws%0d_done", i), 32'(done), 32'd0);
      start = (i == 1);
      isLoad = 1'b0;
      isStore = 1'b1;
      m.mem_ready = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ws_done", 32'(done), 32'd1);
    chk("ws_fault", 32'(fault), 32'd0);
    chk("ws_load", loadData, 32'hCAFEF00D);
    exp_ld = 32'hCAFEF00D;
    @(negedge clk);
    chk("ws_nodone2", 32'(done), 32'd0);
    chk("ws_nobusy", 32'(busy), 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    m.mem_ready = 1'b0;
    m.mem_rdata = 32'h0BADBEEF;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (!m.mem_req) break;
      n++;
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_done", 32'(done), 32'd1);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_keep", loadData, exp_ld);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    @(negedge clk);
    start = 1'b0;
    chk("rs_req_pre", 32'(m.mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rs_req", 32'(m.mem_req), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_load", loadData, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rs_nodone%0d", i), 32'(done), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle RV32I load/store unit sitting directly downstream of the ALU. It consumes the ALU result (`ALUOut`) as the effective address, rs2 as store data and `funct3` as access size. It runs a request/ready handshake to data memory and returns aligned, sign- or zero-extended load data for writeback. Misaligned accesses, illegal `funct3` values and memory timeouts are reported as a fault; in those cases no write reaches memory.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles in ACCESS without `mem_ready`; 0 disables the timeout. 16-bit counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request a memory operation; sampled only in IDLE.
- `isLoad` in 1: operation is a load.
- `isStore` in 1: operation is a store.
- `funct3` in 3: size/sign. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `ALUOut` in 32: effective byte address.
- `storeData` in 32: rs2 value.
- `mem_addr` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `mem_req` out 1: request valid.
- `mem_we` out 1: 1 = store.
- `mem_wmask` out 4: byte-lane write enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: memory accepts/completes the request this cycle.
- `mem_rdata` in 32: read word; valid when `mem_req && mem_ready`.
- `busy` out 1: high in ACCESS and DONE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; misaligned, illegal `funct3`, or timeout.
- `loadData` out 32: extended load result.

## Operation
- States: IDLE, ACCESS, DONE.
- **Accept (IDLE):** on `start=1` with exactly one of `isLoad`/`isStore` high, capture address, `funct3`, `storeData` and direction.
  - If the captured operation is legal → ACCESS.
  - If it is illegal → DONE with `fault=1`.
  - A `start` with both or neither of `isLoad`/`isStore` high is ignored.
- **Illegal:** halfword with `addr[0]=1`; word with `addr[1:0]≠0`; load `funct3` ∈ {011, 110, 111}; store `funct3` ≥ 011.
- **Store lanes:**
  - SB: `wmask = 4'b0001 << addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - SH: `wmask = 4'b0011 << addr[1:0]`, `wdata = {2{rs2[15:0]}}`.
  - SW: `wmask = 4'b1111`, `wdata = rs2`.
  - Loads drive `wmask = 0`.
- **Load extract:**
  - Byte = `rdata >> (8*addr[1:0])`, low 8 bits; halfword = `rdata >> (8*addr[1:0])`, low 16 bits.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **ACCESS:** `mem_req=1`. Address, `we`, `wmask` and `wdata` are held stable until a rising edge with `mem_ready=1`.
  - On that edge a load registers the extracted value into `loadData`; the FSM then goes → DONE with `fault=0`.
  - Timeout counter starts at 0 on entry and increments each cycle without `mem_ready`. When `TIMEOUT≠0` and the count reaches TIMEOUT: drop `mem_req` and go → DONE with `fault=1`; `loadData` is unchanged.
- **DONE:** `done=1` for one cycle, then → IDLE. `start` asserted while in DONE or ACCESS is ignored; it is not queued.
- `loadData` holds its value until the next successful load. Stores and faults never modify it.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `busy`, `done`, `fault` = 0; `mem_wmask`, `mem_addr`, `mem_wdata`, `loadData` = 0. Reset mid-ACCESS drops `mem_req` immediately; no completion is reported.
- All outputs are registered or decoded from registered state. `mem_rdata` and `mem_ready` feed only registers.
- Legal access with `mem_ready` tied high: `start` at edge 0, `mem_req` high in cycle 1, `done` in cycle 2. `loadData` is valid from cycle 2 onward.
- Each wait cycle adds one cycle of latency.
- Fault at accept: `done` and `fault` high in cycle 1; `mem_req` never asserts.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles; `done`/`fault` follow in the next cycle.
- Back-to-back throughput: a new `start` is accepted in the IDLE cycle after DONE, i.e. at most one op per 3 cycles.

## Structure
- Shared package `rv32_pkg`:
  - funct3 constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, `F3_SB`, `F3_SH`, `F3_SW`.
  - LSU state encoding.
- Sub-module `lsu_data_align`, combinational:
  - Inputs: `funct3`, `addr[1:0]`, `storeData`, `mem_rdata`.
  - Outputs: `wmask`, `wdata`, extended load value, `illegal` flag.
- The top level holds the FSM, the capture registers and the timeout counter.

## Test plan
- SW `addr=0x100`, `rs2=0xDEADBEEF`, `mem_ready=1` → `mem_addr=0x100`, `wmask=1111`, `wdata=0xDEADBEEF`, `done` in cycle 2, `fault=0`.
- SB `addr=0x103`, `rs2=0x000000A5` → `wmask=1000`, `wdata=0xA5A5A5A5`. SH `addr=0x102`, `rs2=0x1234` → `wmask=1100`, `wdata=0x12341234`.
- LB/LBU `addr=0x201` with `rdata=0x0000F000` → `loadData = 0xFFFFFFF0` / `0x000000F0`. LH `addr=0x202` with `rdata=0x80010000` → `0xFFFF8001`.
- LW `addr=0x302` → `done` and `fault` in cycle 1, `mem_req` never high, `loadData` unchanged. SH `addr=0x301` → same.
- LW with `mem_ready` held low for 3 cycles → `mem_req` stable for 4 cycles, `done` on the following cycle. `mem_ready` never asserted with `TIMEOUT=16` → `mem_req` high 16 cycles, then `fault`.
- Assert `reset` during an ACCESS wait → `mem_req`, `busy` and `loadData` go to 0 immediately. `start` during `busy` → ignored, no second `done`.
